// File: rtl/id_branch_redirect_pkg.sv
// Shared definitions for the ID-stage branch redirect path: widths, one-hot
// branch opcode bit positions and the redirect FSM state encoding.
package id_branch_redirect_pkg;

    localparam int PC_WIDTH     = 32;
    localparam int BR_OP_WIDTH  = 9;
    localparam int IBUS_WIDTH   = 33;

    localparam int BR_BEQ  = 0;
    localparam int BR_BNE  = 1;
    localparam int BR_BLT  = 2;
    localparam int BR_BGE  = 3;
    localparam int BR_BLTU = 4;
    localparam int BR_BGEU = 5;
    localparam int BR_B    = 6;
    localparam int BR_BL   = 7;
    localparam int BR_JIRL = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } br_state_e;

endpackage

// File: rtl/id_branch_redirect_br_cond_cmp.sv
// Branch condition evaluator for one-hot LoongArch branch opcodes.
// Shared with the EX-stage misprediction checker.
module br_cond_cmp
    import id_branch_redirect_pkg::*;
#(
    parameter int PC_W    = PC_WIDTH,
    parameter int BR_OP_W = BR_OP_WIDTH
) (
    input  logic [BR_OP_W-1:0] i_op,
    input  logic [PC_W-1:0]    i_rj,
    input  logic [PC_W-1:0]    i_rkd,
    output logic               o_cond
);

    logic               w_eq;
    logic               w_lt_s;
    logic               w_lt_u;
    logic [BR_OP_W-1:0] w_hit;

    assign w_eq   = (i_rj == i_rkd);
    assign w_lt_s = ($signed(i_rj) < $signed(i_rkd));
    assign w_lt_u = (i_rj < i_rkd);

    // Per-opcode condition; an all-zero opcode yields no hit
    always_comb begin
        w_hit          = {BR_OP_W{1'b0}};
        w_hit[BR_BEQ]  = i_op[BR_BEQ]  &  w_eq;
        w_hit[BR_BNE]  = i_op[BR_BNE]  & ~w_eq;
        w_hit[BR_BLT]  = i_op[BR_BLT]  &  w_lt_s;
        w_hit[BR_BGE]  = i_op[BR_BGE]  & ~w_lt_s;
        w_hit[BR_BLTU] = i_op[BR_BLTU] &  w_lt_u;
        w_hit[BR_BGEU] = i_op[BR_BGEU] & ~w_lt_u;
        w_hit[BR_B]    = i_op[BR_B];
        w_hit[BR_BL]   = i_op[BR_BL];
        w_hit[BR_JIRL] = i_op[BR_JIRL];
        o_cond         = |w_hit;
    end

endmodule

// File: rtl/id_branch_redirect_chk.sv
// Simulation-only checker: the branch opcode must be one-hot or all-zero.
module id_branch_redirect_chk
    import id_branch_redirect_pkg::*;
#(
    parameter int BR_OP_W = BR_OP_WIDTH
) (
    input logic               clk,
    input logic               rst,
    input logic [BR_OP_W-1:0] id_br_op_i
);

    a_br_op_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(id_br_op_i));

endmodule

// File: rtl/id_branch_redirect.sv
// ID-stage branch resolver: drives the {flag, pc} redirect bus to PreIF and
// holds a taken redirect until PreIF accepts it, stalling ID meanwhile.
module id_branch_redirect
    import id_branch_redirect_pkg::*;
#(
    parameter int PC_W    = PC_WIDTH,
    parameter int BR_OP_W = BR_OP_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               id_valid_i,
    input  logic [BR_OP_W-1:0] id_br_op_i,
    input  logic [PC_W-1:0]    id_pc_i,
    input  logic [PC_W-1:0]    rj_data_i,
    input  logic [PC_W-1:0]    rkd_data_i,
    input  logic [PC_W-1:0]    offs_i,
    input  logic               preif_ready_i,
    output logic [PC_W:0]      id_to_ibus,
    output logic               id_br_stall_o,
    output logic               if_cancel_o
);

    br_state_e         r_state;
    logic [PC_W-1:0]   r_hold_pc;
    logic              w_cond;
    logic              w_taken;
    logic [PC_W-1:0]   w_target;

    br_cond_cmp #(
        .PC_W    (PC_W),
        .BR_OP_W (BR_OP_W)
    ) u_cond (
        .i_op    (id_br_op_i),
        .i_rj    (rj_data_i),
        .i_rkd   (rkd_data_i),
        .o_cond  (w_cond)
    );

    assign w_taken  = id_valid_i & (|id_br_op_i) & w_cond;
    assign w_target = id_br_op_i[BR_JIRL] ? (rj_data_i + offs_i) : (id_pc_i + offs_i);

    // Redirect bus and handshake side-signals; flush masks everything
    always_comb begin
        id_to_ibus    = {1'b0, {PC_W{1'b0}}};
        id_br_stall_o = 1'b0;
        if_cancel_o   = 1'b0;
        if (flush_i) begin
            id_to_ibus    = {1'b0, {PC_W{1'b0}}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_taken) begin
                        id_to_ibus    = {1'b1, w_target};
                        if_cancel_o   = preif_ready_i;
                        id_br_stall_o = ~preif_ready_i;
                    end else begin
                        id_to_ibus    = {1'b0, {PC_W{1'b0}}};
                    end
                end
                ST_HOLD: begin
                    // The instruction now in ID is wrong-path; only the held target counts
                    id_to_ibus    = {1'b1, r_hold_pc};
                    if_cancel_o   = preif_ready_i;
                    id_br_stall_o = ~preif_ready_i;
                end
                default: begin
                    id_to_ibus    = {1'b0, {PC_W{1'b0}}};
                end
            endcase
        end
    end

    // Pending-redirect FSM; reset outranks flush, flush outranks the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_hold_pc <= {PC_W{1'b0}};
        end else if (flush_i) begin
            r_state   <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_taken && !preif_ready_i) begin
                        r_hold_pc <= w_target;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (preif_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_branch_redirect.sv
// Bench for id_branch_redirect: directed scenarios plus randomized traffic,
// compared each cycle against a pending-redirect reference model.
module tb_id_branch_redirect;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        id_valid_i;
    logic [8:0]  id_br_op_i;
    logic [31:0] id_pc_i;
    logic [31:0] rj_data_i;
    logic [31:0] rkd_data_i;
    logic [31:0] offs_i;
    logic        preif_ready_i;
    logic [32:0] id_to_ibus;
    logic        id_br_stall_o;
    logic        if_cancel_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: index of the branch op (-1 none) and one outstanding redirect
    int          cur_idx;
    bit          m_pend;
    logic [31:0] m_pc;

    id_branch_redirect dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .id_valid_i    (id_valid_i),
        .id_br_op_i    (id_br_op_i),
        .id_pc_i       (id_pc_i),
        .rj_data_i     (rj_data_i),
        .rkd_data_i    (rkd_data_i),
        .offs_i        (offs_i),
        .preif_ready_i (preif_ready_i),
        .id_to_ibus    (id_to_ibus),
        .id_br_stall_o (id_br_stall_o),
        .if_cancel_o   (if_cancel_o)
    );

    id_branch_redirect_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .id_br_op_i (id_br_op_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [32:0] bus, input logic stall, input logic cancel);
        check({tag, "_bus"}, id_to_ibus, bus);
        check({tag, "_stall"}, {32'd0, id_br_stall_o}, {32'd0, stall});
        check({tag, "_cancel"}, {32'd0, if_cancel_o}, {32'd0, cancel});
    endtask

    task automatic drive(input bit v, input int idx, input logic [31:0] pc, input logic [31:0] rj,
                         input logic [31:0] rkd, input logic [31:0] offs, input bit rdy);
        logic [8:0] op;
        op = 9'd0;
        if (idx >= 0) op[idx] = 1'b1;
        cur_idx       = idx;
        id_valid_i    = v;
        id_br_op_i    = op;
        id_pc_i       = pc;
        rj_data_i     = rj;
        rkd_data_i    = rkd;
        offs_i        = offs;
        preif_ready_i = rdy;
    endtask

    // One clock: compare against the model, then advance the model at the edge
    task automatic cyc();
        bit          taken;
        logic [31:0] tgt;
        logic [32:0] e_bus;
        bit          e_stall;
        bit          e_cancel;
        #1;
        taken = 1'b0;
        if (id_valid_i && cur_idx >= 0) begin
            case (cur_idx)
                0:       taken = (rj_data_i == rkd_data_i);
                1:       taken = (rj_data_i != rkd_data_i);
                2:       taken = ($signed(rj_data_i) <  $signed(rkd_data_i));
                3:       taken = ($signed(rj_data_i) >= $signed(rkd_data_i));
                4:       taken = (rj_data_i <  rkd_data_i);
                5:       taken = (rj_data_i >= rkd_data_i);
                default: taken = 1'b1;
            endcase
        end
        tgt = (cur_idx == 8) ? rj_data_i + offs_i : id_pc_i + offs_i;
        e_bus = 33'd0; e_stall = 1'b0; e_cancel = 1'b0;
        if (!flush_i) begin
            if (m_pend) begin
                e_bus = {1'b1, m_pc};
                e_stall = !preif_ready_i; e_cancel = preif_ready_i;
            end else if (taken) begin
                e_bus = {1'b1, tgt};
                e_stall = !preif_ready_i; e_cancel = preif_ready_i;
            end
        end
        expect_out("model", e_bus, e_stall, e_cancel);
        @(posedge clk);
        if (rst) begin
            m_pend = 1'b0; m_pc = 32'd0;
        end else if (flush_i) begin
            m_pend = 1'b0;
        end else if (m_pend) begin
            if (preif_ready_i) m_pend = 1'b0;
        end else if (taken && !preif_ready_i) begin
            m_pend = 1'b1; m_pc = tgt;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        drive(1'b0, -1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_pend = 1'b0; m_pc = 32'd0;
        #1 expect_out("reset", 33'd0, 1'b0, 1'b0);
        cyc();
        rst = 1'b0;

        // Taken BEQ accepted in the same cycle
        drive(1'b1, 0, 32'h1C00_0010, 32'd5, 32'd5, 32'h20, 1'b1);
        #1 expect_out("beq", 33'h1_1C00_0030, 1'b0, 1'b1);
        cyc();
        drive(1'b0, -1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        #1 check("beq_after_flag", {32'd0, id_to_ibus[32]}, 33'd0);
        cyc();

        // Signed vs unsigned compare on -1 < 1
        drive(1'b1, 2, 32'h1000, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1);
        #1 expect_out("blt", 33'h1_0000_1040, 1'b0, 1'b1);
        cyc();
        drive(1'b1, 4, 32'h1000, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1);
        #1 expect_out("bltu", 33'd0, 1'b0, 1'b0);
        cyc();

        // JIRL held for three not-ready cycles
        drive(1'b1, 8, 32'h1C00_0000, 32'h1C00_1000, 32'd0, 32'hFFFF_FFFC, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 expect_out("jirl_hold", 33'h1_1C00_0FFC, 1'b1, 1'b0);
            cyc();
            id_valid_i = 1'b0;
        end
        preif_ready_i = 1'b1;
        #1 expect_out("jirl_accept", 33'h1_1C00_0FFC, 1'b0, 1'b1);
        cyc();
        #1 expect_out("jirl_idle", 33'd0, 1'b0, 1'b0);
        cyc();

        // New taken branch while holding is ignored
        drive(1'b1, 0, 32'h1C00_0000, 32'd3, 32'd3, 32'h100, 1'b0);
        cyc();
        drive(1'b1, 1, 32'h1F00, 32'd1, 32'd2, 32'h100, 1'b1);
        #1 expect_out("hold_vs_new", 33'h1_1C00_0100, 1'b0, 1'b1);
        cyc();
        drive(1'b0, -1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        cyc();

        // Flush while holding drops the redirect
        drive(1'b1, 6, 32'h4000, 32'd0, 32'd0, 32'h10, 1'b0);
        cyc();
        flush_i = 1'b1;
        #1 expect_out("flush", 33'd0, 1'b0, 1'b0);
        cyc();
        flush_i = 1'b0;
        drive(1'b0, -1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        #1 expect_out("post_flush", 33'd0, 1'b0, 1'b0);
        cyc();

        // Reset while holding, then a fresh B
        drive(1'b1, 7, 32'h8000, 32'd0, 32'd0, 32'h20, 1'b0);
        cyc();
        rst = 1'b1;
        drive(1'b0, -1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        cyc();
        rst = 1'b0;
        #1 expect_out("post_rst", 33'd0, 1'b0, 1'b0);
        drive(1'b1, 6, 32'h100, 32'd0, 32'd0, 32'h8, 1'b1);
        #1 expect_out("b_after_rst", 33'h1_0000_0108, 1'b0, 1'b1);
        cyc();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] r_a;
            logic [31:0] r_b;
            r_a = $urandom;
            r_b = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
            if ($urandom_range(0, 3) == 0) r_a = {~r_b[31], r_a[30:0]};
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 9)) - 1,
                  {$urandom, 2'b00} & 32'hFFFF_FFFC, r_a, r_b,
                  {{14{1'b0}}, 18'($urandom)} ^ {32{$urandom_range(0, 1) == 1}},
                  $urandom_range(0, 2) != 0);
            flush_i = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 49) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_branch_redirect.md
Name: id_branch_redirect

Overview:
ID-stage branch resolver. It is the producer side of the ID→PreIF redirect bus, which carries {branch_flag, branch_pc} and is consumed by the next-PC mux.
- Evaluates LoongArch branch/jump conditions for the instruction in ID and computes the target.
- Drives the redirect and holds it in a register until PreIF can accept it.
- Signals cancellation of the wrong-path fetch and stalls ID while a redirect is pending.

Parameters:
PC_W, 32, PC and operand width
BR_OP_W, 9, one-hot branch opcode width (BEQ,BNE,BLT,BGE,BLTU,BGEU,B,BL,JIRL)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
flush_i  in  1  exception/ertn flush; highest priority
id_valid_i  in  1  ID holds a valid instruction this cycle
id_br_op_i  in  BR_OP_W  one-hot branch op; all-zero = not a branch
id_pc_i  in  PC_W  PC of the ID instruction
rj_data_i  in  PC_W  rj operand (forwarded)
rkd_data_i  in  PC_W  rk/rd operand (forwarded)
offs_i  in  PC_W  sign-extended, pre-shifted (<<2) offset
preif_ready_i  in  1  PreIF accepts a redirect this cycle
id_to_ibus  out  33 (`IdToPreifBusWidth)  {branch_flag[32], branch_pc[31:0]}
id_br_stall_o  out  1  ID must not advance or issue
if_cancel_o  out  1  discard the instruction currently in IF

Behaviour:
- Condition evaluation, combinational:
  - BEQ/BNE: rj==rkd / rj!=rkd.
  - BLT/BGE: signed compare. BLTU/BGEU: unsigned compare.
  - B/BL/JIRL: always taken.
  - taken = id_valid_i & |id_br_op_i & cond.
- Target arithmetic: JIRL → rj_data_i+offs_i; all others → id_pc_i+offs_i. Mod 2^32, wrap ignored, no alignment check.
- FSM has two states, IDLE and HOLD, plus registers hold_pc[31:0] and state.
- IDLE, taken & preif_ready_i:
  - id_to_ibus={1,target} combinationally in the same cycle (0-cycle latency).
  - if_cancel_o=1, id_br_stall_o=0.
  - Stay in IDLE.
- IDLE, taken & !preif_ready_i:
  - id_to_ibus={1,target} still driven.
  - id_br_stall_o=1. hold_pc<=target. Next state HOLD.
  - if_cancel_o=0.
- IDLE, not taken: id_to_ibus={0,32'h0}, if_cancel_o=0, id_br_stall_o=0.
- HOLD:
  - id_to_ibus={1,hold_pc}. id_valid_i and the operands are ignored (wrong path).
  - If preif_ready_i: if_cancel_o=1, id_br_stall_o=0, next state IDLE.
  - Otherwise: id_br_stall_o=1 and stay in HOLD.
- flush_i, any state:
  - Combinationally forces id_to_ibus flag=0, if_cancel_o=0, id_br_stall_o=0.
  - Next state IDLE. hold_pc is unchanged (don't-care).
- rst=1 at a clock edge: state=IDLE, hold_pc=0. Outputs reflect IDLE with no valid input: bus=0, stall=0, cancel=0. Reset mid-HOLD discards the pending redirect.
- Simultaneous events:
  - flush_i beats rst? No: rst beats flush_i, and flush_i beats everything else.
  - HOLD with preif_ready_i and a new id_valid_i branch in the same cycle: only hold_pc is issued. The new branch is not evaluated.
- Invariant: at most one redirect is outstanding. branch_flag never stays high more than one cycle after acceptance.
- Non-one-hot id_br_op_i: undefined, flagged by a simulation assertion.

Decomposition:
- Shared header (DefineLoogLenWidth.h): `PcWidth, `IdToPreifBusWidth (33), `BrOpWidth, one-hot bit index macros BR_BEQ..BR_JIRL, state encodings.
- Sub-module br_cond_cmp (combinational): op, rj, rkd → cond. It is reused by the EX-stage misprediction checker.

Test Plan:
- BEQ, pc=0x1C000010, rj=rkd=5, offs=0x20, ready=1 → same cycle: bus={1,0x1C000030}, if_cancel=1, stall=0. Next cycle bus flag=0.
- BLT, rj=0xFFFFFFFF (−1), rkd=1 → taken. BLTU with the same operands → not taken, bus={0,0}.
- JIRL, rj=0x1C001000, offs=0xFFFFFFFC, ready=0 for 3 cycles then 1:
  - bus={1,0x1C000FFC} held 4 cycles, stall=1 for 3 cycles.
  - Cancel pulses only in the 4th cycle, then return to IDLE.
- In HOLD, present a new BNE taken to 0x2000 while ready=1 → bus carries the old hold_pc, not 0x2000.
- In HOLD, assert flush_i → bus flag=0 that cycle, stall=0, IDLE next cycle. ready=1 afterwards produces no redirect.
- rst asserted in HOLD → next cycle bus={0,0}, stall=0. A subsequent B, pc=0x100, offs=0x8 → bus={1,0x108}.
